ibex_fetch_aligner: RTL and testbench

- Sits between the prefetch buffer and the compressed decoder in the IF stage.
- Accepts word-aligned 32-bit fetch words through a valid/ready handshake.
- Emits one instruction per handshake, starting at the correct halfword, with its PC and error flags. Handles compressed instructions, 32-bit instructions that span two fetch words, and redirects to halfword-aligned targets.
- Output feeds the compressed decoder's instr_i directly.

---
 rtl/ibex_fetch_pkg.sv | 18 +
 rtl/ibex_fetch_aligner.sv | 162 ++++++++++++++++
 tb/tb_ibex_fetch_aligner.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ibex_fetch_pkg.sv
// rtl/ibex_fetch_pkg.sv - shared types and helpers for the IF-stage fetch aligner
//
// Purpose: aligner state encoding, instruction width and the RVC length test.
package ibex_fetch_pkg;

  localparam int OPC_WIDTH = 32;

  typedef enum logic {
    ALIGN_EMPTY,
    ALIGN_HALF
  } align_state_e;

  // A halfword starts a compressed (16-bit) instruction unless its two LSBs are 2'b11.
  function automatic logic is_compressed(logic [15:0] h);
    return h[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/ibex_fetch_aligner.sv
// rtl/ibex_fetch_aligner.sv - realigns word fetches into one instruction per handshake
//
// Purpose: sits between the prefetch buffer and the compressed decoder. Takes
// word-aligned 32-bit fetch words and emits one instruction per handshake,
// starting at the right halfword, stitching 32-bit instructions that straddle
// two fetch words, and tracking the PC of each emitted instruction.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   clear_i, clear_addr_i      flush/redirect and its target (bit 0 ignored)
//   in_valid_i/in_ready_o      fetch word handshake, data in_rdata_i, bus error in_err_i
//   out_valid_o/out_ready_i    instruction handshake
//   out_rdata_o, out_addr_o    instruction (upper half zero when compressed) and its PC
//   out_is_compressed_o        out_rdata_o[1:0] != 2'b11
//   out_err_o, out_err_plus2_o fetch error on any part / only on the upper half
module ibex_fetch_aligner
  import ibex_fetch_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic [31:0]          clear_addr_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [OPC_WIDTH-1:0] in_rdata_i,
  input  logic                 in_err_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [OPC_WIDTH-1:0] out_rdata_o,
  output logic [31:0]          out_addr_o,
  output logic                 out_is_compressed_o,
  output logic                 out_err_o,
  output logic                 out_err_plus2_o
);

  align_state_e state_q, state_d;
  logic [15:0]  hold_q, hold_d;
  logic         hold_err_q, hold_err_d;
  logic         skip_q, skip_d;
  logic [31:0]  pc_q, pc_d;

  logic [15:0]  lo_h, hi_h;
  logic         word_hs;

  assign lo_h = in_rdata_i[15:0];
  assign hi_h = in_rdata_i[31:16];
  // Wherever input and output handshakes coincide, both reduce to this.
  assign word_hs = in_valid_i & out_ready_i;

  always_comb begin
    state_d         = state_q;
    hold_d          = hold_q;
    hold_err_d      = hold_err_q;
    skip_d          = skip_q;
    pc_d            = pc_q;
    out_valid_o     = 1'b0;
    in_ready_o      = 1'b0;
    out_rdata_o     = in_rdata_i;
    out_err_o       = 1'b0;
    out_err_plus2_o = 1'b0;

    case (state_q)
      ALIGN_EMPTY: begin
        if (!skip_q) begin
          out_valid_o = in_valid_i;
          in_ready_o  = out_ready_i;
          if (in_err_i) begin
            // Faulting word goes out whole; the resulting exception redirects the PC.
            out_err_o = 1'b1;
          end else if (!is_compressed(lo_h)) begin
            if (word_hs) pc_d = pc_q + 32'd4;
          end else begin
            out_rdata_o = {16'h0000, lo_h};
            if (word_hs) begin
              hold_d     = hi_h;
              hold_err_d = 1'b0;
              state_d    = ALIGN_HALF;
              pc_d       = pc_q + 32'd2;
            end
          end
        end else if (is_compressed(hi_h) || in_err_i) begin
          out_valid_o = in_valid_i;
          in_ready_o  = out_ready_i;
          out_rdata_o = {16'h0000, hi_h};
          out_err_o   = in_err_i;
          if (word_hs) begin
            skip_d = 1'b0;
            pc_d   = pc_q + 32'd2;
          end
        end else begin
          // Redirect landed on the first half of a 32-bit instruction: park it
          // and wait for the next word (one bubble).
          in_ready_o = 1'b1;
          if (in_valid_i) begin
            hold_d     = hi_h;
            hold_err_d = 1'b0;
            skip_d     = 1'b0;
            state_d    = ALIGN_HALF;
          end
        end
      end

      ALIGN_HALF: begin
        if (is_compressed(hold_q)) begin
          // Held halfword is a full instruction; no new word is needed.
          out_valid_o = 1'b1;
          out_rdata_o = {16'h0000, hold_q};
          out_err_o   = hold_err_q;
          if (out_ready_i) begin
            state_d = ALIGN_EMPTY;
            pc_d    = pc_q + 32'd2;
          end
        end else begin
          out_valid_o     = in_valid_i;
          in_ready_o      = out_ready_i;
          out_rdata_o     = {lo_h, hold_q};
          out_err_o       = hold_err_q | in_err_i;
          out_err_plus2_o = in_err_i & ~hold_err_q;
          if (word_hs) begin
            hold_d     = hi_h;
            hold_err_d = in_err_i;
            pc_d       = pc_q + 32'd4;
          end
        end
      end

      default: state_d = ALIGN_EMPTY;
    endcase

    if (clear_i) begin
      out_valid_o = 1'b0;
      in_ready_o  = 1'b0;
      state_d     = ALIGN_EMPTY;
      hold_d      = hold_q;
      hold_err_d  = 1'b0;
      pc_d        = clear_addr_i & 32'hFFFF_FFFE;
      skip_d      = clear_addr_i[1];
    end
  end

  assign out_addr_o          = pc_q;
  assign out_is_compressed_o = is_compressed(out_rdata_o[15:0]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ALIGN_EMPTY;
      hold_q     <= 16'h0000;
      hold_err_q <= 1'b0;
      skip_q     <= 1'b0;
      pc_q       <= BOOT_ADDR;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      hold_err_q <= hold_err_d;
      skip_q     <= skip_d;
      pc_q       <= pc_d;
    end
  end

endmodule

// File: tb/tb_ibex_fetch_aligner.sv
// tb/tb_ibex_fetch_aligner.sv - self-checking bench for ibex_fetch_aligner
module tb_ibex_fetch_aligner;

  localparam logic [31:0] BOOT = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic [31:0] clear_addr;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_rdata;
  logic        in_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic [31:0] out_addr;
  logic        out_is_c;
  logic        out_err;
  logic        out_err_p2;

  int n_vec = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  ibex_fetch_aligner #(.BOOT_ADDR(BOOT)) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .clear_i             (clear),
    .clear_addr_i        (clear_addr),
    .in_valid_i          (in_valid),
    .in_ready_o          (in_ready),
    .in_rdata_i          (in_rdata),
    .in_err_i            (in_err),
    .out_valid_o         (out_valid),
    .out_ready_i         (out_ready),
    .out_rdata_o         (out_rdata),
    .out_addr_o          (out_addr),
    .out_is_compressed_o (out_is_c),
    .out_err_o           (out_err),
    .out_err_plus2_o     (out_err_p2)
  );

  always #5 clk = ~clk;

  // Model: a queue of pending halfwords (data + error) plus PC and a skip flag.
  // Each cycle the available halfwords are the queue followed by the halfwords
  // of the presented word; the head instruction needs one or two of them.
  logic [15:0] mq_h[$];
  logic        mq_e[$];
  logic        m_skip;
  logic [31:0] m_pc;

  typedef struct packed {
    logic            valid;
    logic            ready;
    logic [31:0]     rdata;
    logic            err;
    logic            p2;
    int              nq;
    int              na;
    int              needed;
    logic [31:0]     step;
    logic [2:0][15:0] ah;
    logic [2:0]      ae;
  } exp_t;

  function automatic exp_t model_eval();
    exp_t x;
    int   n;
    logic special;
    x = '0;
    x.nq = mq_h.size();
    n = 0;
    for (int i = 0; i < x.nq; i++) begin
      x.ah[n] = mq_h[i];
      x.ae[n] = mq_e[i];
      n++;
    end
    if (!m_skip) begin
      x.ah[n] = in_rdata[15:0];
      x.ae[n] = in_err;
      n++;
    end
    x.ah[n] = in_rdata[31:16];
    x.ae[n] = in_err;
    n++;
    x.na = n;
    // A bad word fetched at a word boundary is handed on as-is without advancing the PC.
    special = (x.nq == 0) && !m_skip && in_err;
    if (special) x.needed = 2;
    else if (x.ah[0][1:0] != 2'b11 || (x.nq == 0 && x.ae[0])) x.needed = 1;
    else x.needed = 2;
    x.step  = special ? 32'd0 : 32'(2 * x.needed);
    x.valid = !clear && ((x.nq >= x.needed) || (in_valid && x.na >= x.needed));
    if (clear || x.nq >= x.needed) x.ready = 1'b0;
    else if (x.na < x.needed) x.ready = 1'b1;
    else x.ready = out_ready;
    if (x.needed == 1) begin
      x.rdata = {16'h0000, x.ah[0]};
      x.err   = x.ae[0];
      x.p2    = 1'b0;
    end else begin
      x.rdata = {x.ah[1], x.ah[0]};
      x.err   = x.ae[0] | x.ae[1];
      x.p2    = x.ae[1] & ~x.ae[0];
    end
    return x;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model_upd
    exp_t x;
    if (!rst_n) begin
      mq_h.delete();
      mq_e.delete();
      m_skip <= 1'b0;
      m_pc   <= BOOT;
    end else begin
      x = model_eval();
      if (clear) begin
        mq_h.delete();
        mq_e.delete();
        m_skip <= clear_addr[1];
        m_pc   <= clear_addr & 32'hFFFF_FFFE;
      end else begin
        if (in_valid && x.ready) begin
          for (int i = x.nq; i < x.na; i++) begin
            mq_h.push_back(x.ah[i]);
            mq_e.push_back(x.ae[i]);
          end
          m_skip <= 1'b0;
        end
        if (x.valid && out_ready) begin
          for (int i = 0; i < x.needed; i++) begin
            void'(mq_h.pop_front());
            void'(mq_e.pop_front());
          end
          m_pc <= m_pc + x.step;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin : compare
    exp_t x;
    if (rst_n && chk_en) begin
      x = model_eval();
      chk("out_valid", 32'(out_valid), 32'(x.valid));
      chk("in_ready", 32'(in_ready), 32'(x.ready));
      if (x.valid) begin
        chk("out_rdata", out_rdata, x.rdata);
        chk("out_addr", out_addr, m_pc);
        chk("out_is_c", 32'(out_is_c), 32'(x.rdata[1:0] != 2'b11));
        chk("out_err", 32'(out_err), 32'(x.err));
        chk("out_err_p2", 32'(out_err_p2), 32'(x.p2));
      end
    end
  end

  task automatic drv(input logic v, input logic [31:0] d, input logic e);
    in_valid = v;
    in_rdata = d;
    in_err   = e;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear = 1'b0;
    in_valid = 1'b0;
    in_err = 1'b0;
    out_ready = 1'b1;
    adv();
    rst_n = 1'b1;
  endtask

  function automatic logic [15:0] mkh();
    logic [15:0] h;
    h = 16'($urandom);
    if ($urandom_range(1, 0) == 1) h[1:0] = 2'b11;
    else if (h[1:0] == 2'b11) h[1:0] = 2'b01;
    return h;
  endfunction

  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    clear_addr = 32'h0;
    in_valid = 1'b0;
    in_rdata = 32'h0;
    in_err = 1'b0;
    out_ready = 1'b1;
    adv();
    adv();
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Reset state with nothing presented.
    drv(1'b0, 32'hDEAD_BEEF, 1'b0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_addr", out_addr, 32'h80);
    chk("rst_rdata", out_rdata, 32'hDEAD_BEEF);
    chk("rst_err", {30'd0, out_err, out_err_p2}, 32'd0);
    adv();

    // Two aligned 32-bit instructions, no bubbles.
    drv(1'b1, 32'h0000_0013, 1'b0);
    chk("nop_rdata", out_rdata, 32'h0000_0013);
    chk("nop_addr", out_addr, 32'h80);
    chk("nop_valid", 32'(out_valid), 32'd1);
    adv();
    drv(1'b1, 32'h00A0_0093, 1'b0);
    chk("li_rdata", out_rdata, 32'h00A0_0093);
    chk("li_addr", out_addr, 32'h84);
    chk("li_is_c", 32'(out_is_c), 32'd0);
    adv();

    // Two compressed instructions in one word.
    do_reset();
    drv(1'b1, 32'h4505_0001, 1'b0);
    chk("cnop_rdata", out_rdata, 32'h0000_0001);
    chk("cnop_addr", out_addr, 32'h80);
    chk("cnop_is_c", 32'(out_is_c), 32'd1);
    adv();
    drv(1'b0, 32'h0, 1'b0);
    chk("cli_valid", 32'(out_valid), 32'd1);
    chk("cli_ready", 32'(in_ready), 32'd0);
    chk("cli_rdata", out_rdata, 32'h0000_4505);
    chk("cli_addr", out_addr, 32'h82);
    adv();

    // Compressed then a spanning 32-bit instruction, leaving 16'h1234 held.
    do_reset();
    drv(1'b1, 32'h0093_0001, 1'b0);
    chk("span0_rdata", out_rdata, 32'h0000_0001);
    adv();
    drv(1'b1, 32'h1234_00A0, 1'b0);
    chk("span_rdata", out_rdata, 32'h00A0_0093);
    chk("span_addr", out_addr, 32'h82);
    adv();
    drv(1'b0, 32'h0, 1'b0);
    chk("held_rdata", out_rdata, 32'h0000_1234);
    chk("held_addr", out_addr, 32'h86);
    adv();

    // Redirect to a halfword target holding the first half of a 32-bit instruction.
    clear = 1'b1;
    clear_addr = 32'h0000_0102;
    drv(1'b1, 32'h0513_ABCD, 1'b0);
    chk("clr_valid", 32'(out_valid), 32'd0);
    chk("clr_ready", 32'(in_ready), 32'd0);
    adv();
    clear = 1'b0;
    drv(1'b1, 32'h0513_ABCD, 1'b0);
    chk("bubble_valid", 32'(out_valid), 32'd0);
    chk("bubble_ready", 32'(in_ready), 32'd1);
    adv();
    drv(1'b1, 32'h0000_0000, 1'b0);
    chk("redir_rdata", out_rdata, 32'h0000_0513);
    chk("redir_addr", out_addr, 32'h102);
    adv();

    // Error on the upper half of a spanning instruction, then an inherited hold error.
    do_reset();
    drv(1'b1, 32'h0093_0001, 1'b0);
    adv();
    drv(1'b1, 32'h0013_0000, 1'b1);
    chk("e2_rdata", out_rdata, 32'h0000_0093);
    chk("e2_err", 32'(out_err), 32'd1);
    chk("e2_p2", 32'(out_err_p2), 32'd1);
    adv();
    drv(1'b1, 32'h0000_00A0, 1'b0);
    chk("eh_rdata", out_rdata, 32'h00A0_0013);
    chk("eh_err", 32'(out_err), 32'd1);
    chk("eh_p2", 32'(out_err_p2), 32'd0);
    adv();

    // Clear during an output handshake discards the instruction.
    do_reset();
    drv(1'b1, 32'h4505_0001, 1'b0);
    adv();
    clear = 1'b1;
    clear_addr = 32'h0000_0201;
    drv(1'b0, 32'h0, 1'b0);
    chk("clrhs_valid", 32'(out_valid), 32'd0);
    adv();
    clear = 1'b0;
    drv(1'b1, 32'h0000_0013, 1'b0);
    chk("clrhs_addr", out_addr, 32'h200);
    chk("clrhs_rdata", out_rdata, 32'h0000_0013);
    adv();

    // Asynchronous reset mid-HALF.
    drv(1'b1, 32'h0093_0001, 1'b0);
    adv();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_addr", out_addr, 32'h80);
    chk("arst_valid", 32'(out_valid), 32'd0);
    adv();
    rst_n = 1'b1;
    drv(1'b1, 32'h0000_0013, 1'b0);
    chk("arst_rdata", out_rdata, 32'h0000_0013);
    adv();

    // PC wrap from the top halfword.
    clear = 1'b1;
    clear_addr = 32'hFFFF_FFFE;
    drv(1'b0, 32'h0, 1'b0);
    adv();
    clear = 1'b0;
    drv(1'b1, 32'h4505_0000, 1'b0);
    chk("wrap_rdata", out_rdata, 32'h0000_4505);
    chk("wrap_addr", out_addr, 32'hFFFF_FFFE);
    adv();
    drv(1'b1, 32'h0000_0013, 1'b0);
    chk("wrap0_addr", out_addr, 32'h0);
    adv();

    // Randomised traffic checked every cycle by the model.
    for (int i = 0; i < 4000; i++) begin
      in_valid  = ($urandom_range(3, 0) != 0);
      out_ready = ($urandom_range(3, 0) != 0);
      in_err    = ($urandom_range(15, 0) == 0);
      clear     = ($urandom_range(31, 0) == 0);
      clear_addr = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                               : $urandom;
      in_rdata  = {mkh(), mkh()};
      adv();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
